id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the register file.
- Latches register-file read data, immediate and ID control into EX.
- Performs load-use hazard detection (stall plus bubble) and an ID-stage write-back bypass.
- Produces registered forwarding selects for the EX operand muxes and keeps a saturating stall counter.

Parameters:
- CW, 12, width of the packed ID control bundle: RegWr, MemtoReg[1:0], MemWr, MemRd, ALUSrc, ALUctr[3:0], Branch, Jump.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- ID_busA  in  32  register-file port A data.
- ID_busB  in  32  register-file port B data.
- ID_Ra  in  5  rs index.
- ID_Rb  in  5  rt index.
- ID_Rw  in  5  destination index.
- ID_UseRa  in  1  instruction reads rs.
- ID_UseRb  in  1  instruction reads rt.
- ID_Imm32  in  32  extended immediate.
- ID_PC  in  32  PC+4 of the ID instruction.
- ID_Ctrl  in  CW  packed control.
- Mem_Rw, Mem_RegWr, Mem_MemtoReg[1:0]  in  5/1/2  MEM-stage destination info.
- Wr_Rw, Wr_RegWr, Wr_MemtoReg[1:0], Wr_RegDi  in  5/1/2/32  WB-stage write info, same bus that drives the register file.
- Ex_Flush  in  1  branch/jump taken in EX; squash the ID instruction.
- ID_Stall  out  1  combinational; hold PC and IF/ID this cycle.
- Ex_busA, Ex_busB  out  32 each  latched operands.
- Ex_Imm32, Ex_PC  out  32 each  latched immediate and PC.
- Ex_Ra, Ex_Rb, Ex_Rw  out  5 each  latched indices.
- Ex_Ctrl  out  CW  latched control.
- Ex_FwdA, Ex_FwdB  out  2 each  00 = latched bus, 01 = forward from MEM ALU result, 10 = forward from WB data.
- stall_cnt  out  CNT_W  count of bubbles inserted by load-use stalls.

Behaviour:
- Effective destination of any stage = 31 when MemtoReg == 2'b10 (JAL), else Rw. A stage is a producer only if RegWr = 1 and its effective destination is not 0.
- Load-use stall (combinational): ID_Stall = 1 when all of the following hold:
  - Ex_Ctrl.MemRd = 1 and Ex_Ctrl.RegWr = 1;
  - the EX effective destination is non-zero;
  - it equals ID_Ra with ID_UseRa = 1, or ID_Rb with ID_UseRb = 1;
  - Ex_Flush = 0.
- Ex_Flush forces ID_Stall = 0; flush has priority over stall.
- Reset (rst = 0 at a rising edge): all Ex_* outputs go to 0 (bubble, Ex_Ctrl = 0), Ex_FwdA/B = 00, stall_cnt = 0. ID_Stall evaluates to 0 because Ex_Ctrl = 0. Reset mid-stall discards the held instruction.
- Each rising edge with rst = 1:
  - Ex_Flush = 1 or ID_Stall = 1: load a bubble. Ex_Ctrl = 0, Ex_Rw = 0, Ex_FwdA/B = 00; data fields are don't-care and are driven to 0.
  - Otherwise: latch every ID field into the matching Ex_* output (1-cycle latency).
- ID-stage bypass: when the WB stage is a producer and its effective destination equals ID_Ra, Ex_busA latches Wr_RegDi instead of ID_busA. The register file writes on the same edge, so the read that cycle is stale. Same rule for B.
- Forward selects are computed in ID and registered. For A:
  - the EX stage (not a load) is a producer matching ID_Ra -> Ex_FwdA = 01;
  - else the MEM stage is a producer matching ID_Ra -> Ex_FwdA = 10;
  - else 00.
  - Nearest producer wins. Register 0 never forwards. Same rule for B.
- A stalled instruction is re-presented the next cycle. At that point the load sits in MEM, so it resolves to FwdX = 10. Stall length is exactly 1 cycle per load-use pair.
- stall_cnt increments by 1 on each edge where ID_Stall = 1 and Ex_Flush = 0. It saturates at all-ones and never wraps.

Test Plan:
- Reset: hold rst = 0 for 2 edges with random ID inputs -> all Ex_* = 0, FwdA/B = 00, stall_cnt = 0, ID_Stall = 0.
- Pass-through: ID_busA = 0x11, busB = 0x22, Rw = 5, Ctrl.RegWr = 1, no hazards -> after 1 edge Ex_busA = 0x11, Ex_busB = 0x22, Ex_Rw = 5, FwdA/B = 00.
- Load-use: EX holds lw with Rw = 8; ID has Ra = 8, UseRa = 1 -> ID_Stall = 1, next Ex_Ctrl = 0, stall_cnt = 1. Re-presented instruction gets Ex_FwdA = 10 and ID_Stall = 0.
- Forward priority: EX add Rw = 3 and MEM add Rw = 3; ID Rb = 3 -> Ex_FwdB = 01. With EX Rw = 0 -> Ex_FwdB = 00 regardless of the MEM match? No: with EX Rw = 0, MEM Rw = 3 still matches -> Ex_FwdB = 10. A case where the only matching index is Ra = 0 -> Ex_FwdA = 00.
- WB bypass with JAL: Wr_RegWr = 1, Wr_MemtoReg = 10, Wr_Rw = 4, Wr_RegDi = 0x400010; ID_Ra = 31 -> Ex_busA = 0x400010. With ID_Ra = 4 -> Ex_busA = ID_busA.
- Flush during stall: load-use hazard present and Ex_Flush = 1 -> ID_Stall = 0, bubble loaded, stall_cnt unchanged. Counter preloaded to 0xFFFF then a stall occurs -> stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches ID operands and control into EX, detects load-use
// hazards, bypasses the WB write into the ID read, and registers EX forwarding selects.
module id_ex_stage #(
    parameter int CW    = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ID_busA,
    input  logic [31:0]      ID_busB,
    input  logic [4:0]       ID_Ra,
    input  logic [4:0]       ID_Rb,
    input  logic [4:0]       ID_Rw,
    input  logic             ID_UseRa,
    input  logic             ID_UseRb,
    input  logic [31:0]      ID_Imm32,
    input  logic [31:0]      ID_PC,
    input  logic [CW-1:0]    ID_Ctrl,
    input  logic [4:0]       Mem_Rw,
    input  logic             Mem_RegWr,
    input  logic [1:0]       Mem_MemtoReg,
    input  logic [4:0]       Wr_Rw,
    input  logic             Wr_RegWr,
    input  logic [1:0]       Wr_MemtoReg,
    input  logic [31:0]      Wr_RegDi,
    input  logic             Ex_Flush,
    output logic             ID_Stall,
    output logic [31:0]      Ex_busA,
    output logic [31:0]      Ex_busB,
    output logic [31:0]      Ex_Imm32,
    output logic [31:0]      Ex_PC,
    output logic [4:0]       Ex_Ra,
    output logic [4:0]       Ex_Rb,
    output logic [4:0]       Ex_Rw,
    output logic [CW-1:0]    Ex_Ctrl,
    output logic [1:0]       Ex_FwdA,
    output logic [1:0]       Ex_FwdB,
    output logic [CNT_W-1:0] stall_cnt
);
    // Control bundle layout, MSB first: RegWr, MemtoReg[1:0], MemWr, MemRd, ALUSrc, ALUctr, Branch, Jump
    localparam int         REGWR_BIT = CW - 1;
    localparam int         MTR_HI    = CW - 2;
    localparam int         MTR_LO    = CW - 3;
    localparam int         MEMRD_BIT = CW - 5;
    localparam logic [1:0] MTR_JAL   = 2'b10;

    logic [4:0]  ex_dst;
    logic [4:0]  mem_dst;
    logic [4:0]  wr_dst;
    logic        ex_prod;
    logic        mem_prod;
    logic        wr_prod;
    logic        ex_load;
    logic        hazard;
    logic        bubble;

    logic [4:0]  src_idx  [2];
    logic [31:0] src_bus  [2];
    logic [31:0] bus_next [2];
    logic [1:0]  fwd_next [2];

    // JAL writes the link register regardless of the Rw field
    assign ex_dst  = (Ex_Ctrl[MTR_HI:MTR_LO] == MTR_JAL) ? 5'd31 : Ex_Rw;
    assign mem_dst = (Mem_MemtoReg == MTR_JAL) ? 5'd31 : Mem_Rw;
    assign wr_dst  = (Wr_MemtoReg == MTR_JAL) ? 5'd31 : Wr_Rw;

    assign ex_prod  = Ex_Ctrl[REGWR_BIT] && (ex_dst != 5'd0);
    assign mem_prod = Mem_RegWr && (mem_dst != 5'd0);
    assign wr_prod  = Wr_RegWr && (wr_dst != 5'd0);
    assign ex_load  = ex_prod && Ex_Ctrl[MEMRD_BIT];

    assign hazard   = ex_load && ((ID_UseRa && (ex_dst == ID_Ra)) ||
                                  (ID_UseRb && (ex_dst == ID_Rb)));
    assign ID_Stall = hazard && !Ex_Flush;
    assign bubble   = hazard || Ex_Flush;

    assign src_idx[0] = ID_Ra;
    assign src_idx[1] = ID_Rb;
    assign src_bus[0] = ID_busA;
    assign src_bus[1] = ID_busB;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            // A load in EX cannot forward from MEM; it is handled by the stall instead
            assign fwd_next[gi] = (ex_prod && !Ex_Ctrl[MEMRD_BIT] && (ex_dst == src_idx[gi])) ? 2'b01 :
                                  (mem_prod && (mem_dst == src_idx[gi]))                      ? 2'b10 :
                                                                                                2'b00;
            // Register file is written on this same edge, so its read data is stale
            assign bus_next[gi] = (wr_prod && (wr_dst == src_idx[gi])) ? Wr_RegDi : src_bus[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst || bubble) begin
            Ex_busA  <= '0;
            Ex_busB  <= '0;
            Ex_Imm32 <= '0;
            Ex_PC    <= '0;
            Ex_Ra    <= '0;
            Ex_Rb    <= '0;
            Ex_Rw    <= '0;
            Ex_Ctrl  <= '0;
            Ex_FwdA  <= 2'b00;
            Ex_FwdB  <= 2'b00;
        end else begin
            Ex_busA  <= bus_next[0];
            Ex_busB  <= bus_next[1];
            Ex_Imm32 <= ID_Imm32;
            Ex_PC    <= ID_PC;
            Ex_Ra    <= ID_Ra;
            Ex_Rb    <= ID_Rb;
            Ex_Rw    <= ID_Rw;
            Ex_Ctrl  <= ID_Ctrl;
            Ex_FwdA  <= fwd_next[0];
            Ex_FwdB  <= fwd_next[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (ID_Stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios followed by a randomized
// pipeline run, checked against a rule-level reference model of the EX stage contents.
module tb_id_ex_stage;
    localparam logic [11:0] ADD = 12'h800;
    localparam logic [11:0] LW  = 12'hA80;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ID_busA, ID_busB, ID_Imm32, ID_PC, Wr_RegDi;
    logic [4:0]  ID_Ra, ID_Rb, ID_Rw, Mem_Rw, Wr_Rw;
    logic        ID_UseRa, ID_UseRb, Mem_RegWr, Wr_RegWr, Ex_Flush;
    logic [11:0] ID_Ctrl;
    logic [1:0]  Mem_MemtoReg, Wr_MemtoReg;

    logic        ID_Stall, s_ID_Stall;
    logic [31:0] Ex_busA, Ex_busB, Ex_Imm32, Ex_PC;
    logic [31:0] s_Ex_busA, s_Ex_busB, s_Ex_Imm32, s_Ex_PC;
    logic [4:0]  Ex_Ra, Ex_Rb, Ex_Rw, s_Ex_Ra, s_Ex_Rb, s_Ex_Rw;
    logic [11:0] Ex_Ctrl, s_Ex_Ctrl;
    logic [1:0]  Ex_FwdA, Ex_FwdB, s_Ex_FwdA, s_Ex_FwdB;
    logic [15:0] stall_cnt;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.CW(12), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ID_busA(ID_busA), .ID_busB(ID_busB), .ID_Ra(ID_Ra), .ID_Rb(ID_Rb),
        .ID_Rw(ID_Rw), .ID_UseRa(ID_UseRa), .ID_UseRb(ID_UseRb), .ID_Imm32(ID_Imm32), .ID_PC(ID_PC),
        .ID_Ctrl(ID_Ctrl), .Mem_Rw(Mem_Rw), .Mem_RegWr(Mem_RegWr), .Mem_MemtoReg(Mem_MemtoReg),
        .Wr_Rw(Wr_Rw), .Wr_RegWr(Wr_RegWr), .Wr_MemtoReg(Wr_MemtoReg), .Wr_RegDi(Wr_RegDi),
        .Ex_Flush(Ex_Flush), .ID_Stall(ID_Stall), .Ex_busA(Ex_busA), .Ex_busB(Ex_busB),
        .Ex_Imm32(Ex_Imm32), .Ex_PC(Ex_PC), .Ex_Ra(Ex_Ra), .Ex_Rb(Ex_Rb), .Ex_Rw(Ex_Rw),
        .Ex_Ctrl(Ex_Ctrl), .Ex_FwdA(Ex_FwdA), .Ex_FwdB(Ex_FwdB), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, so saturation is reachable quickly
    id_ex_stage #(.CW(12), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .ID_busA(ID_busA), .ID_busB(ID_busB), .ID_Ra(ID_Ra), .ID_Rb(ID_Rb),
        .ID_Rw(ID_Rw), .ID_UseRa(ID_UseRa), .ID_UseRb(ID_UseRb), .ID_Imm32(ID_Imm32), .ID_PC(ID_PC),
        .ID_Ctrl(ID_Ctrl), .Mem_Rw(Mem_Rw), .Mem_RegWr(Mem_RegWr), .Mem_MemtoReg(Mem_MemtoReg),
        .Wr_Rw(Wr_Rw), .Wr_RegWr(Wr_RegWr), .Wr_MemtoReg(Wr_MemtoReg), .Wr_RegDi(Wr_RegDi),
        .Ex_Flush(Ex_Flush), .ID_Stall(s_ID_Stall), .Ex_busA(s_Ex_busA), .Ex_busB(s_Ex_busB),
        .Ex_Imm32(s_Ex_Imm32), .Ex_PC(s_Ex_PC), .Ex_Ra(s_Ex_Ra), .Ex_Rb(s_Ex_Rb), .Ex_Rw(s_Ex_Rw),
        .Ex_Ctrl(s_Ex_Ctrl), .Ex_FwdA(s_Ex_FwdA), .Ex_FwdB(s_Ex_FwdB), .stall_cnt(s_stall_cnt)
    );

    typedef struct packed {
        logic        stall;
        logic        chk;
        logic [31:0] bus_a, bus_b, imm, pc;
        logic [4:0]  ra, rb, rw;
        logic [11:0] ctrl;
        logic [1:0]  fa, fb;
        logic [15:0] cnt;
        logic [3:0]  cnt_s;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   m_cnt = 0;
    bit   last_stall = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    function automatic logic [4:0] dest(input logic [4:0] rw, input logic [1:0] mtr);
        return (mtr == 2'b10) ? 5'd31 : rw;
    endfunction

    function automatic bit prod(input logic wr, input logic [4:0] rw, input logic [1:0] mtr);
        return wr && (dest(rw, mtr) != 5'd0);
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] r);
        if (prod(m.ctrl[11], m.rw, m.ctrl[10:9]) && !m.ctrl[7] && dest(m.rw, m.ctrl[10:9]) == r)
            return 2'b01;
        if (prod(Mem_RegWr, Mem_Rw, Mem_MemtoReg) && dest(Mem_Rw, Mem_MemtoReg) == r)
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] bypass(input logic [4:0] r, input logic [31:0] rd);
        if (prod(Wr_RegWr, Wr_Rw, Wr_MemtoReg) && dest(Wr_Rw, Wr_MemtoReg) == r) return Wr_RegDi;
        return rd;
    endfunction

    // Predict this edge's effect from the current inputs and the modelled EX contents
    task automatic cycle(input bit chk);
        exp_t e;
        logic [4:0] ed;
        bit stall;
        ed    = dest(m.rw, m.ctrl[10:9]);
        stall = !Ex_Flush && m.ctrl[11] && m.ctrl[7] && ed != 5'd0 &&
                ((ID_UseRa && ed == ID_Ra) || (ID_UseRb && ed == ID_Rb));
        e = '0;
        if (!rst) begin
            m_cnt = 0;
        end else if (Ex_Flush || stall) begin
            if (stall) m_cnt++;
        end else begin
            e.bus_a = bypass(ID_Ra, ID_busA);
            e.bus_b = bypass(ID_Rb, ID_busB);
            e.imm   = ID_Imm32;
            e.pc    = ID_PC;
            e.ra    = ID_Ra;
            e.rb    = ID_Rb;
            e.rw    = ID_Rw;
            e.ctrl  = ID_Ctrl;
            e.fa    = fwd(ID_Ra);
            e.fb    = fwd(ID_Rb);
        end
        e.stall = stall;
        e.chk   = chk;
        e.cnt   = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        e.cnt_s = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
        q.push_back(e);
        m = e;
        last_stall = stall;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (txn %0d)", name, act, exp, n_txn);
        end
    endtask

    // Monitor: sample the combinational stall mid-cycle, registered outputs just after the edge
    initial begin
        exp_t e;
        logic st;
        forever begin
            @(negedge clk);
            #2 st = ID_Stall;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) chk("id_stall", {31'd0, st}, {31'd0, e.stall});
                chk("ex_busA", Ex_busA, e.bus_a);
                chk("ex_busB", Ex_busB, e.bus_b);
                chk("ex_imm32", Ex_Imm32, e.imm);
                chk("ex_pc", Ex_PC, e.pc);
                chk("ex_ra", {27'd0, Ex_Ra}, {27'd0, e.ra});
                chk("ex_rb", {27'd0, Ex_Rb}, {27'd0, e.rb});
                chk("ex_rw", {27'd0, Ex_Rw}, {27'd0, e.rw});
                chk("ex_ctrl", {20'd0, Ex_Ctrl}, {20'd0, e.ctrl});
                chk("ex_fwdA", {30'd0, Ex_FwdA}, {30'd0, e.fa});
                chk("ex_fwdB", {30'd0, Ex_FwdB}, {30'd0, e.fb});
                chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt});
                chk("stall_cnt_sat", {28'd0, s_stall_cnt}, {28'd0, e.cnt_s});
                $display("txn %0d stall=%0b ctrl=%h rw=%0d fwd=%0d/%0d cnt=%0d/%0d",
                         n_txn, st, Ex_Ctrl, Ex_Rw, Ex_FwdA, Ex_FwdB, stall_cnt, s_stall_cnt);
                n_txn++;
            end
        end
    end

    task automatic set_id(input logic [11:0] c, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rw, input bit ua, input bit ub);
        ID_Ctrl = c; ID_Ra = ra; ID_Rb = rb; ID_Rw = rw; ID_UseRa = ua; ID_UseRb = ub;
        ID_busA = $urandom; ID_busB = $urandom; ID_Imm32 = $urandom; ID_PC = $urandom;
    endtask

    task automatic set_mem(input logic [4:0] rw, input logic wr, input logic [1:0] mtr);
        Mem_Rw = rw; Mem_RegWr = wr; Mem_MemtoReg = mtr;
    endtask

    task automatic set_wr(input logic [4:0] rw, input logic wr, input logic [1:0] mtr, input logic [31:0] d);
        Wr_Rw = rw; Wr_RegWr = wr; Wr_MemtoReg = mtr; Wr_RegDi = d;
    endtask

    task automatic rand_id();
        set_id(12'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        if ($urandom_range(0, 2) == 0) ID_Ctrl = (ID_Ctrl & 12'h17F) | LW;
    endtask

    initial begin
        m = '0;
        rst = 1'b0;
        Ex_Flush = 1'b0;
        rand_id();
        set_mem(5'($urandom), 1'($urandom), 2'($urandom));
        set_wr(5'($urandom), 1'($urandom), 2'($urandom), $urandom);
        @(negedge clk);

        // Reset with random ID inputs
        cycle(1'b0);
        rand_id();
        cycle(1'b1);
        rst = 1'b1;
        set_mem(0, 0, 0);
        set_wr(0, 0, 0, 0);

        // Pass-through
        set_id(ADD, 1, 2, 5, 1, 1);
        ID_busA = 32'h11;
        ID_busB = 32'h22;
        cycle(1'b1);

        // Load-use stall, then re-presentation with the load in MEM
        set_id(LW, 1, 2, 8, 1, 0);
        cycle(1'b1);
        set_mem(5, 1, 0);
        set_id(ADD, 8, 2, 9, 1, 1);
        cycle(1'b1);
        set_mem(8, 1, 2'b01);
        set_wr(5, 1, 0, $urandom);
        cycle(1'b1);

        // Forward priority and register-0 cases
        set_mem(0, 0, 0);
        set_wr(0, 0, 0, 0);
        set_id(ADD, 1, 1, 3, 0, 0);
        cycle(1'b1);
        set_mem(3, 1, 0);
        set_id(ADD, 1, 3, 6, 1, 1);
        cycle(1'b1);
        set_mem(6, 1, 0);
        set_id(ADD, 1, 1, 0, 0, 0);
        cycle(1'b1);
        set_mem(3, 1, 0);
        set_id(ADD, 1, 3, 7, 1, 1);
        cycle(1'b1);
        set_mem(0, 1, 0);
        set_id(ADD, 0, 4, 2, 1, 1);
        cycle(1'b1);

        // WB bypass with a JAL writer
        set_mem(0, 0, 0);
        set_wr(4, 1, 2'b10, 32'h0040_0010);
        set_id(ADD, 31, 4, 2, 1, 1);
        cycle(1'b1);
        set_id(ADD, 4, 31, 2, 1, 1);
        cycle(1'b1);

        // Flush beats a pending load-use stall
        set_wr(0, 0, 0, 0);
        set_id(LW, 1, 1, 8, 0, 0);
        cycle(1'b1);
        set_id(ADD, 8, 8, 2, 1, 1);
        Ex_Flush = 1'b1;
        cycle(1'b1);
        Ex_Flush = 1'b0;

        // Reset while stalled discards the held instruction
        set_id(LW, 1, 1, 8, 0, 0);
        cycle(1'b1);
        set_id(ADD, 8, 1, 2, 1, 0);
        rst = 1'b0;
        cycle(1'b1);
        rst = 1'b1;

        // Randomized run with MEM/WB following the modelled pipeline
        for (int i = 0; i < 3000; i++) begin
            set_wr(Mem_Rw, Mem_RegWr, Mem_MemtoReg, $urandom);
            set_mem(m.rw, m.ctrl[11], m.ctrl[10:9]);
            if ($urandom_range(0, 7) == 0) begin
                set_mem(5'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
                set_wr(5'($urandom_range(0, 7)), 1'($urandom), 2'($urandom), $urandom);
            end
            if (!last_stall) rand_id();
            Ex_Flush = ($urandom_range(0, 9) == 0);
            cycle(1'b1);
        end
        Ex_Flush = 1'b0;

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
